// File: rtl/mtm_riscv_soc_pkg.sv
// Shared types and constants for the SoC data bus endpoints.
package mtm_riscv_soc_pkg;

  // Transaction phases of the data bus responder.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } data_bus_responder_state_t;

  // Read data returned with any error response.
  localparam logic [31:0] DATA_BUS_ERR_RDATA = 32'h0;

endpackage : mtm_riscv_soc_pkg

// File: rtl/bus_timeout_counter.sv
// Saturating cycle counter that flags when TIMEOUT_CYCLES enabled cycles
// have elapsed since the last clear.
module bus_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == LIMIT);

  // Next count: clear wins, otherwise count up and hold at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : bus_timeout_counter

// File: rtl/data_bus_responder.sv
// Slave endpoint of the core data bus: turns one req/gnt/rvalid transaction
// into one req/ack register access with any number of wait states.
// Misaligned accesses are answered with an error without touching the
// register port. Defining DATA_BUS_RESPONDER_TIMEOUT_EN adds an ACCESS
// watchdog that forces an error response after TIMEOUT_CYCLES cycles.
module data_bus_responder
  import mtm_riscv_soc_pkg::*;
#(
  parameter int unsigned OFFSET_WIDTH   = 12,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    data_bus_req,
  input  logic                    data_bus_we,
  input  logic [3:0]              data_bus_be,
  input  logic [31:0]             data_bus_addr,
  input  logic [31:0]             data_bus_wdata,
  output logic                    data_bus_gnt,
  output logic                    data_bus_rvalid,
  output logic [31:0]             data_bus_rdata,
  output logic                    data_bus_err,
  output logic                    reg_req,
  output logic                    reg_we,
  output logic [3:0]              reg_be,
  output logic [OFFSET_WIDTH-1:0] reg_offset,
  output logic [31:0]             reg_wdata,
  input  logic                    reg_ack,
  input  logic [31:0]             reg_rdata,
  input  logic                    reg_err
);

  data_bus_responder_state_t state_q, state_d;
  logic                    we_q, we_d;
  logic [3:0]              be_q, be_d;
  logic [OFFSET_WIDTH-1:0] offset_q, offset_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic                    expired;
  logic                    misaligned;

  assign misaligned = (data_bus_addr[1:0] != 2'b00);

  // Upper address bits are consumed by the decoder in front of this block.
  logic unused_addr_bits;
  assign unused_addr_bits = ^data_bus_addr[31:OFFSET_WIDTH];

`ifdef DATA_BUS_RESPONDER_TIMEOUT_EN
  bus_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state_q != ACCESS),
    .enable  (state_q == ACCESS),
    .expired (expired)
  );
`else
  assign expired = 1'b0;
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = (TIMEOUT_CYCLES != 0);
`endif

  // Next-state, capture and handshake logic for the three transaction phases.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d      = state_q;
    we_d         = we_q;
    be_d         = be_q;
    offset_d     = offset_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    data_bus_gnt = 1'b0;
    reg_req      = 1'b0;

    unique case (state_q)
      IDLE: begin
        data_bus_gnt = data_bus_req;
        if (data_bus_req) begin
          we_d     = data_bus_we;
          be_d     = data_bus_be;
          offset_d = data_bus_addr[OFFSET_WIDTH-1:0];
          wdata_d  = data_bus_wdata;
          if (misaligned) begin
            rdata_d = DATA_BUS_ERR_RDATA;
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        // Once the watchdog fires the peripheral is released, but an ack
        // arriving in that same cycle still delivers its data.
        reg_req = !expired;
        if (reg_ack) begin
          rdata_d = we_q ? 32'h0 : reg_rdata;
          err_d   = reg_err;
          state_d = RESP;
        end else if (expired) begin
          rdata_d = DATA_BUS_ERR_RDATA;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and capture registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      be_q     <= '0;
      offset_q <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge value of the others, independent of statement order.
      state_q  <= state_d;
      we_q     <= we_d;
      be_q     <= be_d;
      offset_q <= offset_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign reg_we          = we_q;
  assign reg_be          = be_q;
  assign reg_offset      = offset_q;
  assign reg_wdata       = wdata_q;
  assign data_bus_rvalid = (state_q == RESP);
  assign data_bus_rdata  = data_bus_rvalid ? rdata_q : 32'h0;
  assign data_bus_err    = data_bus_rvalid & err_q;

endmodule : data_bus_responder

// File: tb/tb_data_bus_responder.sv
// Randomized self-checking bench for data_bus_responder. Expected latency,
// response data and register-port activity come from a transaction-level
// model: misaligned -> 1 cycle, error, no register access; otherwise
// k+1 register request cycles and a response 2+k cycles after the grant.
module tb_data_bus_responder;

  localparam int OW = 12;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          data_bus_req;
  logic          data_bus_we;
  logic [3:0]    data_bus_be;
  logic [31:0]   data_bus_addr;
  logic [31:0]   data_bus_wdata;
  logic          data_bus_gnt;
  logic          data_bus_rvalid;
  logic [31:0]   data_bus_rdata;
  logic          data_bus_err;
  logic          reg_req;
  logic          reg_we;
  logic [3:0]    reg_be;
  logic [OW-1:0] reg_offset;
  logic [31:0]   reg_wdata;
  logic          reg_ack;
  logic [31:0]   reg_rdata;
  logic          reg_err;

  int vectors = 0;
  int fails   = 0;

  data_bus_responder #(
    .OFFSET_WIDTH   (OW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .data_bus_req    (data_bus_req),
    .data_bus_we     (data_bus_we),
    .data_bus_be     (data_bus_be),
    .data_bus_addr   (data_bus_addr),
    .data_bus_wdata  (data_bus_wdata),
    .data_bus_gnt    (data_bus_gnt),
    .data_bus_rvalid (data_bus_rvalid),
    .data_bus_rdata  (data_bus_rdata),
    .data_bus_err    (data_bus_err),
    .reg_req         (reg_req),
    .reg_we          (reg_we),
    .reg_be          (reg_be),
    .reg_offset      (reg_offset),
    .reg_wdata       (reg_wdata),
    .reg_ack         (reg_ack),
    .reg_rdata       (reg_rdata),
    .reg_err         (reg_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Runs one transaction starting just after a rising edge with the DUT idle.
  // k = wait states before the peripheral acks.
  task automatic run_txn(input logic we, input logic [3:0] be, input logic [31:0] addr,
                         input logic [31:0] wdata, input int k,
                         input logic [31:0] prdata, input logic perr);
    bit          misal;
    int          exp_lat;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          reqs;
    bit          got;
    misal     = (addr % 4) != 0;
    exp_lat   = misal ? 1 : 2 + k;
    exp_rdata = (misal || we) ? 32'h0 : prdata;
    exp_err   = misal ? 1'b1 : perr;

    data_bus_req   = 1'b1;
    data_bus_we    = we;
    data_bus_be    = be;
    data_bus_addr  = addr;
    data_bus_wdata = wdata;
    @(negedge clk);
    check("gnt_idle", {31'h0, data_bus_gnt}, 32'h1);
    @(posedge clk); #1;
    data_bus_req   = 1'b0;
    data_bus_addr  = $urandom;
    data_bus_wdata = $urandom;

    reqs = 0;
    got  = 0;
    for (int cyc = 1; cyc <= k + 10 && !got; cyc++) begin
      reg_ack   = reg_req && (reqs == k);
      reg_rdata = reg_ack ? prdata : $urandom;
      reg_err   = reg_ack ? perr : 1'($urandom);
      @(negedge clk);
      if (reg_req) begin
        if (reqs == 0) begin
          check("reg_we", {31'h0, reg_we}, {31'h0, we});
          check("reg_be", {28'h0, reg_be}, {28'h0, be});
          check("reg_offset", {20'h0, reg_offset}, {20'h0, addr[OW-1:0]});
          check("reg_wdata", reg_wdata, wdata);
        end
        reqs++;
      end
      if (data_bus_rvalid) begin
        got = 1;
        check("rvalid_latency", cyc, exp_lat);
        check("rdata", data_bus_rdata, exp_rdata);
        check("err", {31'h0, data_bus_err}, {31'h0, exp_err});
      end else begin
        check("idle_rdata_err", {data_bus_rdata[30:0], data_bus_err}, 32'h0);
      end
      @(posedge clk); #1;
      reg_ack = 1'b0;
    end
    if (!got) check("rvalid_seen", 32'h0, 32'h1);
    check("reg_req_cycles", reqs, misal ? 0 : k + 1);
  endtask

  initial begin
    logic [31:0] a;
    int          seen;
    int          reqs;
    rst_n          = 1'b0;
    data_bus_req   = 1'b0;
    data_bus_we    = 1'b0;
    data_bus_be    = '0;
    data_bus_addr  = '0;
    data_bus_wdata = '0;
    reg_ack        = 1'b0;
    reg_rdata      = '0;
    reg_err        = 1'b0;

    // Reset state.
    #12;
    check("rst_gnt", {31'h0, data_bus_gnt}, 32'h0);
    check("rst_rvalid", {31'h0, data_bus_rvalid}, 32'h0);
    check("rst_rdata", data_bus_rdata, 32'h0);
    check("rst_err", {31'h0, data_bus_err}, 32'h0);
    check("rst_reg_req", {31'h0, reg_req}, 32'h0);
    check("rst_reg_we", {31'h0, reg_we}, 32'h0);
    check("rst_reg_be", {28'h0, reg_be}, 32'h0);
    check("rst_reg_offset", {20'h0, reg_offset}, 32'h0);
    check("rst_reg_wdata", reg_wdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases.
    run_txn(1'b0, 4'hF, 32'h0000_0104, 32'h0, 0, 32'hCAFE_0001, 1'b0);
    run_txn(1'b1, 4'b0011, 32'h0000_0208, 32'h1234_5678, 3, 32'hDEAD_BEEF, 1'b0);
    run_txn(1'b0, 4'hF, 32'h0000_0102, 32'h0, 0, 32'h5555_AAAA, 1'b0);
    run_txn(1'b0, 4'hF, 32'h0000_0010, 32'h0, 1, 32'h0BAD_F00D, 1'b1);

    // Randomized transactions.
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      if ($urandom_range(3) != 0) a[1:0] = 2'b00;
      run_txn(1'($urandom), 4'($urandom), a, $urandom, int'($urandom_range(3)),
              $urandom, ($urandom_range(4) == 0));
    end

    // Back-to-back with req held and the peripheral always acking:
    // one grant every 3 cycles, response 2 cycles after each grant.
    reg_ack       = 1'b1;
    reg_rdata     = 32'h0000_00B2;
    data_bus_req  = 1'b1;
    data_bus_we   = 1'b0;
    data_bus_addr = 32'h0000_0020;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check("b2b_gnt", {31'h0, data_bus_gnt}, {31'h0, (i % 3) == 0});
      check("b2b_rvalid", {31'h0, data_bus_rvalid}, {31'h0, (i % 3) == 2});
      @(posedge clk); #1;
    end
    data_bus_req = 1'b0;
    reg_ack      = 1'b0;
    @(posedge clk); #1;

`ifdef DATA_BUS_RESPONDER_TIMEOUT_EN
    // Silent peripheral: reg_req for TO cycles, error response at N+TO+2.
    data_bus_req  = 1'b1;
    data_bus_addr = 32'h0000_0040;
    @(negedge clk);
    check("to_gnt", {31'h0, data_bus_gnt}, 32'h1);
    @(posedge clk); #1;
    data_bus_req = 1'b0;
    reqs = 0;
    seen = 0;
    for (int cyc = 1; cyc <= TO + 6 && seen == 0; cyc++) begin
      @(negedge clk);
      if (reg_req) reqs++;
      if (data_bus_rvalid) begin
        seen = cyc;
        check("to_err", {31'h0, data_bus_err}, 32'h1);
        check("to_rdata", data_bus_rdata, 32'h0);
      end
      @(posedge clk); #1;
    end
    check("to_latency", seen, TO + 2);
    check("to_reg_req_cycles", reqs, TO);
`endif

    // Stalled access, then reset in the middle of ACCESS.
    data_bus_req  = 1'b1;
    data_bus_addr = 32'h0000_0080;
    @(negedge clk);
    check("stall_gnt", {31'h0, data_bus_gnt}, 32'h1);
    @(posedge clk); #1;
    data_bus_req = 1'b0;
    seen = 0;
`ifdef DATA_BUS_RESPONDER_TIMEOUT_EN
    for (int cyc = 0; cyc < 2; cyc++) begin
`else
    for (int cyc = 0; cyc < 100; cyc++) begin
`endif
      @(negedge clk);
      if (data_bus_rvalid) seen++;
      @(posedge clk); #1;
    end
    check("stall_no_rvalid", seen, 0);
    check("stall_reg_req", {31'h0, reg_req}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_reg_req", {31'h0, reg_req}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    reqs = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (data_bus_rvalid) seen++;
      if (reg_req) reqs++;
    end
    check("post_rst_no_rvalid", seen, 0);
    check("post_rst_no_reg_req", reqs, 0);
    @(posedge clk); #1;
    run_txn(1'b0, 4'hF, 32'h0000_0300, 32'h0, 2, 32'h7777_1234, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule : tb_data_bus_responder

// File: doc/data_bus_responder.md
# data_bus_responder

Slave-side endpoint of the core data bus: accepts one request at a time and returns exactly one response. Sits between the data bus (after address decode) and a simple peripheral register port (GPIO, SPI, UART, TIMER, PMC). It converts the req/gnt/rvalid protocol into a req/ack register access with an arbitrary number of wait states. It flags errors back to the core.

## Interface
Parameters:
- OFFSET_WIDTH, 12, number of low address bits forwarded as the register offset.
- TIMEOUT_CYCLES, 255, maximum number of ACCESS cycles before a forced error response (1..65535).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- data_bus_req  input  1  request from core, valid when decoded to this slave.
- data_bus_we  input  1  1 = write, 0 = read.
- data_bus_be  input  4  byte enables.
- data_bus_addr  input  32  byte address.
- data_bus_wdata  input  32  write data.
- data_bus_gnt  output  1  request accepted (combinational).
- data_bus_rvalid  output  1  response valid, one-cycle pulse.
- data_bus_rdata  output  32  read data, valid with rvalid.
- data_bus_err  output  1  error flag, valid with rvalid.
- reg_req  output  1  register access request.
- reg_we  output  1  registered copy of data_bus_we.
- reg_be  output  4  registered copy of data_bus_be.
- reg_offset  output  OFFSET_WIDTH  registered data_bus_addr[OFFSET_WIDTH-1:0].
- reg_wdata  output  32  registered write data.
- reg_ack  input  1  access complete; may be asserted in the same cycle as reg_req.
- reg_rdata  input  32  read data, sampled with reg_ack.
- reg_err  input  1  peripheral error, sampled with reg_ack.

## Operation
- The FSM has three states: IDLE, ACCESS, RESP.
- IDLE:
  - data_bus_gnt = data_bus_req.
  - On req, capture we/be/addr offset/wdata into registers and go to ACCESS.
- ACCESS:
  - reg_req = 1, and it is held until reg_ack.
  - On reg_ack, capture the response: rdata = reg_rdata on a read and 0 on a write; err = reg_err. Then go to RESP.
  - A request presented in ACCESS is not granted (gnt = 0) and must be held by the core.
- RESP:
  - data_bus_rvalid = 1 for exactly one cycle; rdata/err are driven from the capture registers.
  - Then go to IDLE. No grant in RESP.
- Misaligned access (data_bus_addr[1:0] != 0) is still granted but skips ACCESS. It goes IDLE -> RESP with err = 1 and rdata = 0, and reg_req is never asserted.
- data_bus_rdata is 0 whenever rvalid = 0.
- data_bus_err is 0 whenever rvalid = 0.

## Timing
- Reset values:
  - state = IDLE.
  - gnt, rvalid, err, reg_req, reg_we = 0.
  - rdata, reg_be, reg_offset, reg_wdata = 0.
- Request granted in cycle N, reg_req high from N+1.
- Zero-wait peripheral (ack in N+1) gives rvalid in N+2.
- k wait states give rvalid in N+2+k.
- Misaligned access gives rvalid in N+1.
- Maximum throughput is one transaction per 3 cycles. The next grant is possible in the cycle after rvalid.
- reg_ack outside ACCESS is ignored.
- Reset asserted mid-transaction:
  - Immediate return to IDLE, no response is generated, and reg_req drops asynchronously.
  - The pending transaction is discarded.

## Configuration
- DATA_BUS_RESPONDER_TIMEOUT_EN defined:
  - A cycle counter runs in ACCESS.
  - If reg_ack has not arrived after TIMEOUT_CYCLES cycles in ACCESS, force RESP with err = 1 and rdata = 0, and drop reg_req.
  - The counter clears on entry to ACCESS.
  - A reg_ack in the same cycle as the timeout wins; its data is returned.
- Not defined:
  - No counter is built, and ACCESS waits indefinitely for reg_ack.
  - The TIMEOUT_CYCLES parameter is unused.

## Structure
- The FSM state enum data_bus_responder_state_t (IDLE, ACCESS, RESP) goes in mtm_riscv_soc_pkg.
- The constant DATA_BUS_ERR_RDATA = 32'h0 also goes in mtm_riscv_soc_pkg.
- One sub-module, bus_timeout_counter, is instantiated only under DATA_BUS_RESPONDER_TIMEOUT_EN:
  - inputs: clk, rst_n, clear, enable.
  - output: expired.
  - counter width: $clog2(TIMEOUT_CYCLES+1).

## Test plan
- Read, zero wait: req at addr 0x0000_0104 with reg_ack+reg_rdata 0xCAFE_0001 in the same cycle -> gnt N, reg_offset 0x104, rvalid N+2, rdata 0xCAFE_0001, err 0.
- Write with 3 wait states: wdata 0x1234_5678, be 4'b0011 -> reg_we = 1, reg_be = 4'b0011 held for 4 cycles, rvalid N+5, rdata 0, err 0.
- Misaligned read at addr 0x0000_0102 -> gnt N, reg_req never high, rvalid N+1, err 1, rdata 0.
- Back-to-back: req held high continuously -> grants at N, N+3, N+6, and gnt = 0 in ACCESS and RESP.
- Peripheral error: reg_ack with reg_err = 1 -> rvalid with err = 1.
- Timeout, with TIMEOUT_EN defined and TIMEOUT_CYCLES = 4: reg_ack is never asserted -> reg_req high 4 cycles, rvalid N+6, err 1. Rerun with the macro undefined -> no rvalid within 100 cycles.
- Reset during ACCESS -> reg_req drops immediately, and no rvalid after reset release.
